// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD cell-draw sequencer: FSM states, panel command
// bytes, object codes and the object-to-RGB565 palette.
package lcd_pkg;

    typedef enum logic [3:0] {
        S_INIT_SLPOUT,
        S_INIT_WAIT,
        S_COLMOD,
        S_COLMOD_D,
        S_DISPON,
        S_IDLE,
        S_CASET,
        S_PASET,
        S_RAMWR,
        S_PIX,
        S_DONE
    } state_t;

    localparam logic [7:0] CMD_SLPOUT     = 8'h11;
    localparam logic [7:0] CMD_COLMOD     = 8'h3A;
    localparam logic [7:0] COLMOD_RGB565  = 8'h55;
    localparam logic [7:0] CMD_DISPON     = 8'h29;
    localparam logic [7:0] CMD_CASET      = 8'h2A;
    localparam logic [7:0] CMD_PASET      = 8'h2B;
    localparam logic [7:0] CMD_RAMWR      = 8'h2C;

    localparam logic [2:0] OBJ_BG     = 3'd0;
    localparam logic [2:0] OBJ_BODY   = 3'd1;
    localparam logic [2:0] OBJ_HEAD   = 3'd2;
    localparam logic [2:0] OBJ_APPLE  = 3'd3;
    localparam logic [2:0] OBJ_BORDER = 3'd4;

    // Last valid grid row; rows above this are rejected without bus traffic.
    localparam logic [3:0] ROW_MAX = 4'd11;

    function automatic logic [15:0] obj2rgb565(input logic [2:0] code);
        case (code)
            OBJ_BODY:   return 16'h07E0;
            OBJ_HEAD:   return 16'h03E0;
            OBJ_APPLE:  return 16'hF800;
            OBJ_BORDER: return 16'hFFFF;
            default:    return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_mux.sv
// Combinational byte selector: turns the sequencer state, byte index and latched cell
// into the command/data flag and byte presented on the LCD write bus.
module lcd_byte_mux
    import lcd_pkg::*;
#(
    parameter int CELL_PX = 20
) (
    input  state_t      state,
    input  logic [2:0]  byte_sel,
    input  logic [3:0]  cell_x,
    input  logic [3:0]  cell_y,
    input  logic [2:0]  cell_obj,
    output logic        wr_dc,
    output logic [7:0]  wr_data
);

    logic [15:0] xs, xe, ys, ye, colour;

    assign xs     = 16'(cell_x) * 16'(CELL_PX);
    assign xe     = xs + 16'(CELL_PX - 1);
    assign ys     = 16'(cell_y) * 16'(CELL_PX);
    assign ye     = ys + 16'(CELL_PX - 1);
    assign colour = obj2rgb565(cell_obj);

    // Address window parameters go out start-hi, start-lo, end-hi, end-lo.
    function automatic logic [7:0] coord_byte(input logic [2:0] sel,
                                              input logic [15:0] lo,
                                              input logic [15:0] hi);
        case (sel)
            3'd1:    return lo[15:8];
            3'd2:    return lo[7:0];
            3'd3:    return hi[15:8];
            default: return hi[7:0];
        endcase
    endfunction

    always_comb begin
        wr_dc   = 1'b0;
        wr_data = 8'h00;
        case (state)
            S_INIT_SLPOUT: wr_data = CMD_SLPOUT;
            S_COLMOD:      wr_data = CMD_COLMOD;
            S_COLMOD_D: begin
                wr_dc   = 1'b1;
                wr_data = COLMOD_RGB565;
            end
            S_DISPON:      wr_data = CMD_DISPON;
            S_CASET: begin
                if (byte_sel == 3'd0) begin
                    wr_data = CMD_CASET;
                end else begin
                    wr_dc   = 1'b1;
                    wr_data = coord_byte(byte_sel, xs, xe);
                end
            end
            S_PASET: begin
                if (byte_sel == 3'd0) begin
                    wr_data = CMD_PASET;
                end else begin
                    wr_dc   = 1'b1;
                    wr_data = coord_byte(byte_sel, ys, ye);
                end
            end
            S_RAMWR:       wr_data = CMD_RAMWR;
            S_PIX: begin
                wr_dc   = 1'b1;
                wr_data = byte_sel[0] ? colour[7:0] : colour[15:8];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_cell_draw_ctrl.sv
// LCD write-bus sequencer: runs the panel init script after reset, then paints one grid
// cell per accepted request (window setup, RAMWR, solid fill) and pulses cmd_done.
module lcd_cell_draw_ctrl
    import lcd_pkg::*;
#(
    parameter int CELL_PX     = 20,
    parameter int WAIT_CYCLES = 1200
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       draw_req,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [2:0] obj_code,
    output logic       req_ready,
    output logic       cmd_done,
    output logic       range_err,
    output logic       init_done,
    output logic       wr_valid,
    output logic       wr_dc,
    output logic [7:0] wr_data,
    input  logic       wr_ready
);

    localparam int PIX_BYTES = 2 * CELL_PX * CELL_PX;
    localparam int PIX_W     = $clog2(PIX_BYTES);
    localparam int IDX_W     = (PIX_W < 3) ? 3 : PIX_W;
    localparam int WAIT_W    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);

    state_t             state;
    logic [IDX_W-1:0]   byte_idx;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [3:0]         lat_x, lat_y;
    logic [2:0]         lat_obj;
    logic               xfer;

    assign xfer = wr_valid & wr_ready;

    lcd_byte_mux #(
        .CELL_PX (CELL_PX)
    ) u_byte_mux (
        .state    (state),
        .byte_sel (byte_idx[2:0]),
        .cell_x   (lat_x),
        .cell_y   (lat_y),
        .cell_obj (lat_obj),
        .wr_dc    (wr_dc),
        .wr_data  (wr_data)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= S_INIT_SLPOUT;
            byte_idx  <= '0;
            wait_cnt  <= '0;
            lat_x     <= '0;
            lat_y     <= '0;
            lat_obj   <= '0;
            wr_valid  <= 1'b1;
            req_ready <= 1'b0;
            cmd_done  <= 1'b0;
            range_err <= 1'b0;
            init_done <= 1'b0;
        end else begin
            cmd_done  <= 1'b0;
            range_err <= 1'b0;
            case (state)
                S_INIT_SLPOUT: if (xfer) begin
                    state    <= S_INIT_WAIT;
                    wr_valid <= 1'b0;
                    wait_cnt <= '0;
                end
                // Panel needs a quiet bus while it leaves sleep mode.
                S_INIT_WAIT: begin
                    if (wait_cnt == WAIT_W'(WAIT_CYCLES - 1)) begin
                        state    <= S_COLMOD;
                        wr_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_COLMOD:   if (xfer) state <= S_COLMOD_D;
                S_COLMOD_D: if (xfer) state <= S_DISPON;
                S_DISPON: if (xfer) begin
                    state     <= S_IDLE;
                    wr_valid  <= 1'b0;
                    init_done <= 1'b1;
                    req_ready <= 1'b1;
                end
                S_IDLE: if (draw_req) begin
                    lat_x     <= x;
                    lat_y     <= y;
                    lat_obj   <= obj_code;
                    byte_idx  <= '0;
                    req_ready <= 1'b0;
                    if (y > ROW_MAX) begin
                        state     <= S_DONE;
                        cmd_done  <= 1'b1;
                        range_err <= 1'b1;
                    end else begin
                        state    <= S_CASET;
                        wr_valid <= 1'b1;
                    end
                end
                S_CASET: if (xfer) begin
                    if (byte_idx == IDX_W'(4)) begin
                        byte_idx <= '0;
                        state    <= S_PASET;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                S_PASET: if (xfer) begin
                    if (byte_idx == IDX_W'(4)) begin
                        byte_idx <= '0;
                        state    <= S_RAMWR;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                S_RAMWR: if (xfer) begin
                    byte_idx <= '0;
                    state    <= S_PIX;
                end
                // Even index = colour high byte, odd = low byte.
                S_PIX: if (xfer) begin
                    if (byte_idx == IDX_W'(PIX_BYTES - 1)) begin
                        byte_idx <= '0;
                        wr_valid <= 1'b0;
                        cmd_done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= S_INIT_SLPOUT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cell_draw_ctrl.sv
// Bench for lcd_cell_draw_ctrl: drives init, draws, stalls and resets, and compares the
// bus byte stream against a reference built from the cell geometry and palette.
module tb_lcd_cell_draw_ctrl;

    localparam int CELL_PX     = 20;
    localparam int WAIT_CYCLES = 1200;
    localparam int DRAW_BYTES  = 11 + 2 * CELL_PX * CELL_PX;

    logic       tb_clk = 1'b0;
    logic       nrst = 1'b1;
    logic       draw_req = 1'b0;
    logic [3:0] x = '0;
    logic [3:0] y = '0;
    logic [2:0] obj_code = '0;
    logic       wr_ready = 1'b1;
    logic       req_ready, cmd_done, range_err, init_done, wr_valid, wr_dc;
    logic [7:0] wr_data;

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;

    logic [8:0]  got_q[$];
    logic [8:0]  exp_q[$];
    logic [15:0] pal [8] = '{16'h0000, 16'h07E0, 16'h03E0, 16'hF800,
                             16'hFFFF, 16'h0000, 16'h0000, 16'h0000};

    int done_k, ready_k, done_cnt, valid_cnt;
    bit rerr_seen, rerr_stray;

    lcd_cell_draw_ctrl #(
        .CELL_PX     (CELL_PX),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk       (tb_clk),
        .nrst      (nrst),
        .draw_req  (draw_req),
        .x         (x),
        .y         (y),
        .obj_code  (obj_code),
        .req_ready (req_ready),
        .cmd_done  (cmd_done),
        .range_err (range_err),
        .init_done (init_done),
        .wr_valid  (wr_valid),
        .wr_dc     (wr_dc),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready)
    );

    always #5 tb_clk = ~tb_clk;

    always @(posedge tb_clk) begin
        #1;
        case (rdy_mode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = ~wr_ready;
            default: wr_ready = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference: the bytes a cell redraw must put on the bus, from geometry and palette.
    function automatic void push_word(input int w);
        logic [15:0] v;
        v = 16'(w);
        exp_q.push_back({1'b1, v[15:8]});
        exp_q.push_back({1'b1, v[7:0]});
    endfunction

    function automatic void model_draw(input int mx, input int my, input int mo);
        logic [15:0] c;
        exp_q.delete();
        if (my > 11) return;
        c = pal[mo];
        exp_q.push_back({1'b0, 8'h2A});
        push_word(mx * CELL_PX);
        push_word(mx * CELL_PX + CELL_PX - 1);
        exp_q.push_back({1'b0, 8'h2B});
        push_word(my * CELL_PX);
        push_word(my * CELL_PX + CELL_PX - 1);
        exp_q.push_back({1'b0, 8'h2C});
        for (int i = 0; i < CELL_PX * CELL_PX; i++) begin
            exp_q.push_back({1'b1, c[15:8]});
            exp_q.push_back({1'b1, c[7:0]});
        end
    endfunction

    function automatic int diff_count();
        int n = 0;
        if (got_q.size() != exp_q.size()) return -1;
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    // Issue one request, then watch the bus until req_ready returns after cmd_done.
    task automatic do_draw(input int dx, input int dy, input int dobj);
        bit         prev_stall = 0;
        logic [8:0] prev_b = '0;
        int         n = 0;
        @(posedge tb_clk); #1;
        while (!req_ready && n < 5000) begin
            @(posedge tb_clk); #1;
            n++;
        end
        draw_req = 1'b1;
        x = 4'(dx);
        y = 4'(dy);
        obj_code = 3'(dobj);
        @(posedge tb_clk); #1;
        draw_req = 1'b0;
        x = 4'($urandom);
        y = 4'($urandom);
        obj_code = 3'($urandom);
        got_q.delete();
        done_k = -1; ready_k = -1; done_cnt = 0; valid_cnt = 0;
        rerr_seen = 0; rerr_stray = 0;
        for (int k = 1; k <= 5000; k++) begin
            @(negedge tb_clk);
            if (prev_stall) begin
                checks++;
                if (!wr_valid || {wr_dc, wr_data} !== prev_b) begin
                    errors++;
                    $display("FAIL stall_hold k=%0d: got v=%b byte=%h, required v=1 byte=%h",
                             k, wr_valid, {wr_dc, wr_data}, prev_b);
                end
            end
            prev_stall = wr_valid && !wr_ready;
            prev_b = {wr_dc, wr_data};
            if (wr_valid) valid_cnt++;
            if (wr_valid && wr_ready) got_q.push_back({wr_dc, wr_data});
            if (cmd_done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (range_err && cmd_done) rerr_seen = 1;
            if (range_err && !cmd_done) rerr_stray = 1;
            if (req_ready && done_k > 0) begin
                ready_k = k;
                break;
            end
        end
    endtask

    // Capture the init script from the current point until init_done rises.
    task automatic run_init();
        int stamp[$];
        int busy_ready = 0;
        got_q.delete();
        rdy_mode = 0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge tb_clk);
            if (wr_valid && wr_ready) begin
                got_q.push_back({wr_dc, wr_data});
                stamp.push_back(k);
            end
            if (req_ready && !init_done) busy_ready++;
            if (init_done) break;
        end
        draw_req = 1'b0;
        exp_q = '{9'h011, 9'h03A, 9'h155, 9'h029};
        checks++;
        if (diff_count() != 0) begin
            errors++;
            $display("FAIL init_bytes: got %0d bytes (first %h), required 4 bytes 011 03A 155 029",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 9'h1FF);
        end
        checks++;
        if (stamp.size() < 2 || stamp[1] - stamp[0] != WAIT_CYCLES + 1) begin
            errors++;
            $display("FAIL init_gap: got %0d, required %0d",
                     (stamp.size() < 2) ? -1 : stamp[1] - stamp[0], WAIT_CYCLES + 1);
        end
        checks++;
        if (init_done !== 1'b1 || req_ready !== 1'b1 || busy_ready != 0) begin
            errors++;
            $display("FAIL init_status: init_done=%b req_ready=%b early_ready=%0d, required 1 1 0",
                     init_done, req_ready, busy_ready);
        end
        repeat (4) @(negedge tb_clk);
        checks++;
        if (wr_valid !== 1'b0 || req_ready !== 1'b1 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_idle: wr_valid=%b req_ready=%b init_done=%b, required 0 1 1",
                     wr_valid, req_ready, init_done);
        end
    endtask

    task automatic test_reset();
        #3 nrst = 1'b0;
        #10;
        checks++;
        if (wr_valid !== 1'b1 || wr_data !== 8'h11 || wr_dc !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: got v=%b dc=%b data=%h, required 1 0 11", wr_valid, wr_dc, wr_data);
        end
        checks++;
        if ({req_ready, cmd_done, range_err, init_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000", {req_ready, cmd_done, range_err, init_done});
        end
        repeat (3) @(posedge tb_clk);
        #1 nrst = 1'b1;
    endtask

    task automatic test_init();
        x = 4'd3; y = 4'd3; obj_code = 3'd1;
        draw_req = 1'b1;
        run_init();
    endtask

    task automatic test_draw_basic();
        rdy_mode = 0;
        do_draw(4, 4, 2);
        model_draw(4, 4, 2);
        checks++;
        if (diff_count() != 0) begin
            errors++;
            $display("FAIL basic_bytes: got %0d bytes (%0d differ), required %0d bytes",
                     got_q.size(), diff_count(), exp_q.size());
        end
        checks++;
        if (done_k != DRAW_BYTES + 1 || ready_k != DRAW_BYTES + 2) begin
            errors++;
            $display("FAIL basic_latency: cmd_done at %0d req_ready at %0d, required %0d %0d",
                     done_k, ready_k, DRAW_BYTES + 1, DRAW_BYTES + 2);
        end
        checks++;
        if (done_cnt != 1 || rerr_seen || rerr_stray) begin
            errors++;
            $display("FAIL basic_done: pulses=%0d range_err=%b, required 1 0", done_cnt, rerr_seen | rerr_stray);
        end
    endtask

    task automatic test_draw_stall();
        rdy_mode = 1;
        do_draw(15, 11, 4);
        rdy_mode = 0;
        model_draw(15, 11, 4);
        checks++;
        if (diff_count() != 0) begin
            errors++;
            $display("FAIL stall_bytes: got %0d bytes (%0d differ), required %0d bytes",
                     got_q.size(), diff_count(), exp_q.size());
        end
        checks++;
        if (done_cnt != 1 || rerr_seen || rerr_stray || ready_k < 0) begin
            errors++;
            $display("FAIL stall_done: pulses=%0d range_err=%b ready_k=%0d, required 1 0 >0",
                     done_cnt, rerr_seen | rerr_stray, ready_k);
        end
    endtask

    task automatic test_range_err();
        rdy_mode = 0;
        do_draw(2, 12, 3);
        checks++;
        if (valid_cnt != 0) begin
            errors++;
            $display("FAIL range_bus: got %0d valid cycles, required 0", valid_cnt);
        end
        checks++;
        if (done_k != 1 || ready_k != 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL range_done: cmd_done at %0d req_ready at %0d pulses %0d, required 1 2 1",
                     done_k, ready_k, done_cnt);
        end
        checks++;
        if (!rerr_seen || rerr_stray) begin
            errors++;
            $display("FAIL range_flag: with_done=%b stray=%b, required 1 0", rerr_seen, rerr_stray);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] one[$];
        int dn = 0, both = 0, n = 0;
        rdy_mode = 0;
        model_draw(1, 2, 3);
        one = exp_q;
        foreach (one[i]) exp_q.push_back(one[i]);
        got_q.delete();
        @(negedge tb_clk);
        x = 4'd1; y = 4'd2; obj_code = 3'd3;
        draw_req = 1'b1;
        while (dn < 2 && n < 5000) begin
            @(negedge tb_clk);
            n++;
            if (wr_valid && wr_ready) got_q.push_back({wr_dc, wr_data});
            if (cmd_done) dn++;
            if (cmd_done && req_ready) both++;
        end
        draw_req = 1'b0;
        checks++;
        if (diff_count() != 0) begin
            errors++;
            $display("FAIL b2b_bytes: got %0d bytes (%0d differ), required %0d bytes",
                     got_q.size(), diff_count(), exp_q.size());
        end
        checks++;
        if (dn != 2 || both != 0) begin
            errors++;
            $display("FAIL b2b_done: pulses=%0d overlap=%0d, required 2 0", dn, both);
        end
        repeat (5) @(negedge tb_clk);
        checks++;
        if (wr_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: wr_valid=%b req_ready=%b, required 0 1", wr_valid, req_ready);
        end
    endtask

    task automatic test_random();
        int rx, ry, ro;
        for (int t = 0; t < 4; t++) begin
            rx = $urandom_range(0, 15);
            ry = $urandom_range(0, 13);
            ro = $urandom_range(0, 7);
            rdy_mode = 2;
            do_draw(rx, ry, ro);
            rdy_mode = 0;
            model_draw(rx, ry, ro);
            checks++;
            if (diff_count() != 0) begin
                errors++;
                $display("FAIL rand_bytes x=%0d y=%0d obj=%0d: got %0d bytes (%0d differ), required %0d",
                         rx, ry, ro, got_q.size(), diff_count(), exp_q.size());
            end
            checks++;
            if (done_cnt != 1 || rerr_seen != (ry > 11) || rerr_stray) begin
                errors++;
                $display("FAIL rand_done y=%0d: pulses=%0d range_err=%b, required 1 %b",
                         ry, done_cnt, rerr_seen, ry > 11);
            end
        end
    endtask

    task automatic test_reset_midfill();
        int n = 0;
        rdy_mode = 0;
        @(posedge tb_clk); #1;
        draw_req = 1'b1;
        x = 4'd7; y = 4'd5; obj_code = 3'd3;
        @(posedge tb_clk); #1;
        draw_req = 1'b0;
        repeat (300) @(negedge tb_clk);
        checks++;
        if (wr_valid !== 1'b1 || wr_dc !== 1'b1) begin
            errors++;
            $display("FAIL midfill_busy: wr_valid=%b wr_dc=%b, required 1 1", wr_valid, wr_dc);
        end
        nrst = 1'b0;
        #1;
        checks++;
        if (wr_valid !== 1'b1 || wr_data !== 8'h11 || wr_dc !== 1'b0 ||
            {req_ready, cmd_done, range_err, init_done} !== 4'b0000) begin
            errors++;
            $display("FAIL midfill_reset: v=%b dc=%b data=%h ctrl=%b, required 1 0 11 0000",
                     wr_valid, wr_dc, wr_data, {req_ready, cmd_done, range_err, init_done});
        end
        while (n < 3) begin
            @(posedge tb_clk);
            n++;
        end
        #1 nrst = 1'b1;
        run_init();
    endtask

    initial begin
        test_reset();
        test_init();
        test_draw_basic();
        test_draw_stall();
        test_range_err();
        test_back_to_back();
        test_random();
        test_reset_midfill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
